// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   MEM pipeline stage. Takes EX results, applies the call/ret stack-pointer
//   adjustment, and runs loads/stores on an external data memory that has
//   variable latency (req/ack handshake). It registers the MEM/WB outputs and
//   stalls upstream while an access is outstanding. An optional ack timeout
//   completes a hung access with zero data and sets a sticky error flag.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid ... wdata_in    EX stage instruction and control fields
//   stall                    hold EX/upstream registers this cycle
//   mem_req/we/addr/wdata    data memory request, driven only while BUSY
//   mem_ack, mem_rdata       memory completion and read data
//   wb_*                     registered MEM/WB slot
//   mem_err                  sticky flag: an access timed out
module mem_stage_ctrl #(
    parameter int DATA_W      = 16,
    parameter int REG_W       = 4,
    parameter int STACK_STEP  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              call_in,
    input  logic              ret_future_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_to_mem_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic              wb_ret_future,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              mem_err
);

    // state | meaning
    // IDLE  | accepting EX instructions; non-memory ops pass through in 1 cycle
    // BUSY  | memory request outstanding with latched fields, waiting for ack
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Timeout fires on the BUSY cycle in which the count would reach TIMEOUT_CYC.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);
    localparam logic              TO_EN = (TIMEOUT_CYC > 0);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              lat_we_q, lat_we_d;
    logic              lat_load_q, lat_load_d;
    logic [DATA_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0] lat_result_q, lat_result_d;
    logic              lat_reg_write_q, lat_reg_write_d;
    logic              lat_mem_to_reg_q, lat_mem_to_reg_d;
    logic              lat_ret_q, lat_ret_d;
    logic [REG_W-1:0]  lat_rd_q, lat_rd_d;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic              wb_ret_future_q, wb_ret_future_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_alu_result_q, wb_alu_result_d;
    logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;

    logic [DATA_W-1:0] adj_result;
    logic [DATA_W-1:0] acc_addr;
    logic              access;
    logic              busy;
    logic              timeout_hit;
    logic              done;

    assign adj_result  = call_in ? (alu_result_in - STEP) : alu_result_in;
    assign acc_addr    = ret_future_in ? (alu_result_in + STEP) : alu_result_in;
    assign access      = ex_valid & (mem_to_reg_in | reg_to_mem_in);
    assign busy        = (state_q == ST_BUSY);
    // A real ack always wins over a timeout landing on the same cycle.
    assign timeout_hit = TO_EN & busy & ~mem_ack & (cnt_q == CNT_LAST);
    assign done        = busy & (mem_ack | timeout_hit);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        lat_we_d         = lat_we_q;
        lat_load_d       = lat_load_q;
        lat_addr_d       = lat_addr_q;
        lat_wdata_d      = lat_wdata_q;
        lat_result_d     = lat_result_q;
        lat_reg_write_d  = lat_reg_write_q;
        lat_mem_to_reg_d = lat_mem_to_reg_q;
        lat_ret_d        = lat_ret_q;
        lat_rd_d         = lat_rd_q;
        wb_valid_d       = wb_valid_q;
        wb_reg_write_d   = wb_reg_write_q;
        wb_mem_to_reg_d  = wb_mem_to_reg_q;
        wb_ret_future_d  = wb_ret_future_q;
        wb_rd_d          = wb_rd_q;
        wb_alu_result_d  = wb_alu_result_q;
        wb_rdata_d       = wb_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    // Store takes priority when both load and store are flagged.
                    lat_we_d         = reg_to_mem_in;
                    lat_load_d       = mem_to_reg_in & ~reg_to_mem_in;
                    lat_addr_d       = acc_addr;
                    lat_wdata_d      = wdata_in;
                    lat_result_d     = adj_result;
                    lat_reg_write_d  = reg_write_in;
                    lat_mem_to_reg_d = mem_to_reg_in;
                    lat_ret_d        = ret_future_in;
                    lat_rd_d         = rd_in;
                    cnt_d            = '0;
                    wb_valid_d       = 1'b0;
                    state_d          = ST_BUSY;
                end else if (ex_valid) begin
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = reg_write_in;
                    wb_mem_to_reg_d = mem_to_reg_in;
                    wb_ret_future_d = ret_future_in;
                    wb_rd_d         = rd_in;
                    wb_alu_result_d = adj_result;
                    wb_rdata_d      = '0;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            default: begin
                if (done) begin
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = lat_reg_write_q;
                    wb_mem_to_reg_d = lat_mem_to_reg_q;
                    wb_ret_future_d = lat_ret_q;
                    wb_rd_d         = lat_rd_q;
                    wb_alu_result_d = lat_result_q;
                    wb_rdata_d      = (lat_load_q & mem_ack) ? mem_rdata : '0;
                    if (!mem_ack) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    wb_valid_d = 1'b0;
                    if (TO_EN) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            err_q            <= 1'b0;
            lat_we_q         <= 1'b0;
            lat_load_q       <= 1'b0;
            lat_addr_q       <= '0;
            lat_wdata_q      <= '0;
            lat_result_q     <= '0;
            lat_reg_write_q  <= 1'b0;
            lat_mem_to_reg_q <= 1'b0;
            lat_ret_q        <= 1'b0;
            lat_rd_q         <= '0;
            wb_valid_q       <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_ret_future_q  <= 1'b0;
            wb_rd_q          <= '0;
            wb_alu_result_q  <= '0;
            wb_rdata_q       <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            err_q            <= err_d;
            lat_we_q         <= lat_we_d;
            lat_load_q       <= lat_load_d;
            lat_addr_q       <= lat_addr_d;
            lat_wdata_q      <= lat_wdata_d;
            lat_result_q     <= lat_result_d;
            lat_reg_write_q  <= lat_reg_write_d;
            lat_mem_to_reg_q <= lat_mem_to_reg_d;
            lat_ret_q        <= lat_ret_d;
            lat_rd_q         <= lat_rd_d;
            wb_valid_q       <= wb_valid_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_mem_to_reg_q  <= wb_mem_to_reg_d;
            wb_ret_future_q  <= wb_ret_future_d;
            wb_rd_q          <= wb_rd_d;
            wb_alu_result_q  <= wb_alu_result_d;
            wb_rdata_q       <= wb_rdata_d;
        end
    end

    // Held instruction is never re-accepted: stall only drops on completion.
    assign stall     = busy ? ~done : access;
    assign mem_req   = busy;
    assign mem_we    = busy & lat_we_q;
    assign mem_addr  = busy ? lat_addr_q : '0;
    assign mem_wdata = busy ? lat_wdata_q : '0;

    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_ret_future = wb_ret_future_q;
    assign wb_rd         = wb_rd_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_rdata      = wb_rdata_q;
    assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
//   Directed bench for mem_stage_ctrl with TIMEOUT_CYC=4. Inputs change 1 ns
//   after the rising edge; outputs are sampled 1 ns later.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        call_in;
    logic        ret_future_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic        reg_to_mem_in;
    logic [3:0]  rd_in;
    logic [15:0] alu_result_in;
    logic [15:0] wdata_in;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic        wb_ret_future;
    logic [3:0]  wb_rd;
    logic [15:0] wb_alu_result;
    logic [15:0] wb_rdata;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_ctrl #(
        .DATA_W(16), .REG_W(4), .STACK_STEP(2), .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .call_in(call_in),
        .ret_future_in(ret_future_in), .reg_write_in(reg_write_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_to_mem_in(reg_to_mem_in),
        .rd_in(rd_in), .alu_result_in(alu_result_in), .wdata_in(wdata_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_ret_future(wb_ret_future),
        .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_rdata(wb_rdata),
        .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        ex_valid      = 1'b0;
        call_in       = 1'b0;
        ret_future_in = 1'b0;
        reg_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
        reg_to_mem_in = 1'b0;
        rd_in         = '0;
        alu_result_in = '0;
        wdata_in      = '0;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] rd, input logic [15:0] alu);
        clr_in();
        ex_valid      = 1'b1;
        reg_write_in  = 1'b1;
        mem_to_reg_in = 1'b1;
        rd_in         = rd;
        alu_result_in = alu;
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        tick();
        tick();
        #1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_wb_alu", wb_alu_result, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        // 1: plain ALU op, one-cycle pass-through
        tick();
        ex_valid = 1'b1; reg_write_in = 1'b1; rd_in = 4'd5; alu_result_in = 16'h1234;
        #1;
        check("alu_stall", stall, 0);
        check("alu_req", mem_req, 0);
        tick();
        clr_in();
        #1;
        check("alu_wb_valid", wb_valid, 1);
        check("alu_wb_result", wb_alu_result, 16'h1234);
        check("alu_wb_rd", wb_rd, 5);
        check("alu_wb_rw", wb_reg_write, 1);
        check("alu_stall2", stall, 0);
        tick();
        check("alu_bubble", wb_valid, 0);

        // 2: call pushes PC, SP wraps 0x0000 -> 0xFFFE
        clr_in();
        ex_valid = 1'b1; call_in = 1'b1; reg_write_in = 1'b1; reg_to_mem_in = 1'b1;
        rd_in = 4'd14; alu_result_in = 16'h0000; wdata_in = 16'h00A0;
        #1;
        check("call_stall_accept", stall, 1);
        check("call_req_accept", mem_req, 0);
        tick();
        // Upstream changes are ignored while BUSY.
        clr_in();
        ex_valid = 1'b1; mem_to_reg_in = 1'b1; alu_result_in = 16'h5555; wdata_in = 16'h9999;
        #1;
        check("call_req", mem_req, 1);
        check("call_we", mem_we, 1);
        check("call_addr", mem_addr, 16'h0000);
        check("call_wdata", mem_wdata, 16'h00A0);
        check("call_stall_busy", stall, 1);
        mem_ack = 1'b1;
        #1;
        check("call_stall_ack", stall, 0);
        tick();
        clr_in();
        #1;
        check("call_wb_valid", wb_valid, 1);
        check("call_wb_result", wb_alu_result, 16'hFFFE);
        check("call_wb_rd", wb_rd, 14);
        check("call_wb_rdata", wb_rdata, 0);
        check("call_req_after", mem_req, 0);
        check("call_we_after", mem_we, 0);
        check("call_wdata_after", mem_wdata, 0);

        // 3: load with ret_future, ack on the 4th BUSY cycle
        load(4'd3, 16'h7FFE);
        ret_future_in = 1'b1;
        #1;
        check("ret_stall_accept", stall, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ret_stall_wait", stall, 1);
            check("ret_req", mem_req, 1);
            check("ret_we", mem_we, 0);
            check("ret_addr", mem_addr, 16'h8000);
            check("ret_wb_bubble", wb_valid, 0);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        check("ret_stall_ack", stall, 0);
        tick();
        clr_in();
        #1;
        check("ret_wb_valid", wb_valid, 1);
        check("ret_wb_rdata", wb_rdata, 16'hBEEF);
        check("ret_wb_result", wb_alu_result, 16'h7FFE);
        check("ret_wb_ret", wb_ret_future, 1);
        check("ret_wb_m2r", wb_mem_to_reg, 1);
        check("ret_wb_rd", wb_rd, 3);
        check("ret_no_err", mem_err, 0);

        // 4: no ack -> timeout on 4th BUSY cycle, zero data, sticky error
        load(4'd7, 16'h0020);
        mem_rdata = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_stall_wait", stall, 1);
            check("to_req", mem_req, 1);
        end
        tick();
        check("to_stall_fire", stall, 0);
        tick();
        clr_in();
        #1;
        check("to_wb_valid", wb_valid, 1);
        check("to_wb_rdata", wb_rdata, 0);
        check("to_wb_rd", wb_rd, 7);
        check("to_err", mem_err, 1);
        check("to_req_after", mem_req, 0);
        tick();
        check("to_err_sticky", mem_err, 1);
        check("to_bubble", wb_valid, 0);

        // 5: back-to-back loads, ack in the first BUSY cycle
        load(4'd1, 16'h0100);
        #1;
        check("b2b_stall1", stall, 1);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        #1;
        check("b2b_addr1", mem_addr, 16'h0100);
        check("b2b_stall_ack1", stall, 0);
        tick();
        load(4'd2, 16'h0200);
        #1;
        check("b2b_wb_valid1", wb_valid, 1);
        check("b2b_wb_rdata1", wb_rdata, 16'h1111);
        check("b2b_wb_rd1", wb_rd, 1);
        check("b2b_req_idle", mem_req, 0);
        check("b2b_stall2", stall, 1);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h2222;
        #1;
        check("b2b_addr2", mem_addr, 16'h0200);
        check("b2b_stall_ack2", stall, 0);
        tick();
        clr_in();
        mem_ack = 1'b1; mem_rdata = 16'h3333;
        #1;
        check("b2b_wb_valid2", wb_valid, 1);
        check("b2b_wb_rdata2", wb_rdata, 16'h2222);
        check("b2b_wb_rd2", wb_rd, 2);
        check("b2b_no_reissue", mem_req, 0);
        tick();
        check("b2b_stray_ack", wb_valid, 0);
        check("b2b_req_end", mem_req, 0);

        // 7: load+store together behaves as a store, no read data
        clr_in();
        ex_valid = 1'b1; mem_to_reg_in = 1'b1; reg_to_mem_in = 1'b1;
        alu_result_in = 16'h0010; wdata_in = 16'h3333;
        tick();
        clr_in();
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        check("ls_we", mem_we, 1);
        check("ls_wdata", mem_wdata, 16'h3333);
        tick();
        clr_in();
        #1;
        check("ls_wb_valid", wb_valid, 1);
        check("ls_wb_rdata", wb_rdata, 0);

        // 6: reset in the middle of an access
        load(4'd9, 16'h0400);
        tick();
        clr_in();
        #1;
        check("rb_req_before", mem_req, 1);
        rst = 1'b1;
        tick();
        check("rb_req", mem_req, 0);
        check("rb_wb_valid", wb_valid, 0);
        check("rb_err_clr", mem_err, 0);
        check("rb_stall", stall, 0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        check("rb_late_ack", wb_valid, 0);
        check("rb_req_late", mem_req, 0);
        clr_in();
        ex_valid = 1'b1; alu_result_in = 16'h0042; rd_in = 4'd4;
        #1;
        check("rb_idle_stall", stall, 0);
        tick();
        clr_in();
        #1;
        check("rb_idle_wb", wb_valid, 1);
        check("rb_idle_result", wb_alu_result, 16'h0042);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
